// File: rtl/sprite_renderer.sv
`default_nettype none
// ============================================================================
//  Module   : sprite_renderer
//  Purpose  : Places one animated W x H sprite on the VGA raster. It supports
//             2^n scaling and horizontal flip, reads an external synchronous
//             sprite ROM, and returns a palette index and hit flag after a
//             fixed 3-cycle pipeline.
//  Revision : 1.0  initial release
// ============================================================================
module sprite_renderer #(
  parameter int SPRITE_W   = 64,
  parameter int SPRITE_H   = 64,
  parameter int FRAMES     = 4,
  parameter int IDX_W      = 4,
  parameter int TRANSP_IDX = 0,
  parameter int ADDR_W     = $clog2(FRAMES*SPRITE_W*SPRITE_H)
) (
  input  logic                      vga_clk,
  input  logic                      Reset,
  input  logic [9:0]                DrawX,
  input  logic [9:0]                DrawY,
  input  logic                      blank,
  input  logic                      frame_tick,
  input  logic [9:0]                pos_x,
  input  logic [9:0]                pos_y,
  input  logic [1:0]                scale,
  input  logic                      flip_h,
  input  logic                      play,
  input  logic                      loop_mode,
  input  logic [3:0]                anim_div,
  output logic [ADDR_W-1:0]         rom_address,
  input  logic [IDX_W-1:0]          rom_q,
  output logic [IDX_W-1:0]          pix_idx,
  output logic                      pix_hit,
  output logic [$clog2(FRAMES)-1:0] anim_frame,
  output logic                      anim_busy
);

  localparam int CX_W = $clog2(SPRITE_W);
  localparam int CY_W = $clog2(SPRITE_H);
  localparam int FR_W = $clog2(FRAMES);
  localparam logic [FR_W-1:0]  LAST_FRAME = FR_W'(FRAMES - 1);
  localparam logic [IDX_W-1:0] TRANSP     = IDX_W'(TRANSP_IDX);

  typedef enum logic [1:0] {
    HOLD = 2'd0,
    PLAY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state;
  logic [3:0]         tick_cnt;
  logic [4:0]         div_eff;

  // Per-frame shadow copies; the raster only ever sees these
  logic [9:0]         sx_pos;
  logic [9:0]         sy_pos;
  logic [1:0]         sc;
  logic               sflip;
  logic [FR_W-1:0]    frame_sh;

  logic signed [10:0] lx;
  logic signed [10:0] ly;
  logic [15:0]        lim_x;
  logic [15:0]        lim_y;
  logic               in_box;
  logic [CX_W-1:0]    cx;
  logic [CY_W-1:0]    cy;

  logic               in_box_d1;
  logic               in_box_d2;
  logic               blank_d1;
  logic               blank_d2;

  assign div_eff = (anim_div == 4'd0) ? 5'd1 : {1'b0, anim_div};

  // Stage-1 geometry: sprite-local coordinates, box test, texel lookup
  always_comb begin
    lx     = $signed({1'b0, DrawX}) - $signed({1'b0, sx_pos});
    ly     = $signed({1'b0, DrawY}) - $signed({1'b0, sy_pos});
    lim_x  = 16'(SPRITE_W) << sc;
    lim_y  = 16'(SPRITE_H) << sc;
    in_box = !lx[10] && !ly[10] &&
             ({6'd0, lx[9:0]} < lim_x) && ({6'd0, ly[9:0]} < lim_y);
    cx     = CX_W'(lx[9:0] >> sc);
    cy     = CY_W'(ly[9:0] >> sc);
    // Power-of-2 width makes W-1-cx a plain bit inversion
    if (sflip) cx = ~cx;
  end

  // Shadow capture plus the 3-stage pixel pipeline (address, ROM wait, output)
  always_ff @(posedge vga_clk or posedge Reset) begin
    if (Reset) begin
      sx_pos      <= '0;
      sy_pos      <= '0;
      sc          <= '0;
      sflip       <= 1'b0;
      rom_address <= '0;
      in_box_d1   <= 1'b0;
      in_box_d2   <= 1'b0;
      blank_d1    <= 1'b0;
      blank_d2    <= 1'b0;
      pix_idx     <= '0;
      pix_hit     <= 1'b0;
    end else begin
      if (frame_tick) begin
        sx_pos <= pos_x;
        sy_pos <= pos_y;
        sc     <= scale;
        sflip  <= flip_h;
      end
      rom_address <= in_box ? ADDR_W'({frame_sh, cy, cx}) : '0;
      in_box_d1   <= in_box;
      blank_d1    <= blank;
      in_box_d2   <= in_box_d1;
      blank_d2    <= blank_d1;
      if (in_box_d2 && blank_d2 && (rom_q != TRANSP)) begin
        pix_idx <= rom_q;
        pix_hit <= 1'b1;
      end else begin
        pix_idx <= '0;
        pix_hit <= 1'b0;
      end
    end
  end

  // Animation FSM; frame_sh takes the post-tick frame so a whole video frame
  // renders from one animation frame even if play restarts mid-frame
  always_ff @(posedge vga_clk or posedge Reset) begin
    if (Reset) begin
      state      <= HOLD;
      tick_cnt   <= '0;
      anim_frame <= '0;
      anim_busy  <= 1'b0;
      frame_sh   <= '0;
    end else if (play) begin
      state      <= PLAY;
      tick_cnt   <= '0;
      anim_frame <= '0;
      anim_busy  <= 1'b1;
      if (frame_tick) frame_sh <= '0;
    end else if (frame_tick) begin
      frame_sh <= anim_frame;
      if (state == PLAY) begin
        if (({1'b0, tick_cnt} + 5'd1) >= div_eff) begin
          tick_cnt <= '0;
          if (anim_frame == LAST_FRAME) begin
            if (loop_mode) begin
              anim_frame <= '0;
              frame_sh   <= '0;
            end else begin
              state     <= DONE;
              anim_busy <= 1'b0;
            end
          end else begin
            anim_frame <= anim_frame + 1'b1;
            frame_sh   <= anim_frame + 1'b1;
            if (!loop_mode && ((anim_frame + 1'b1) == LAST_FRAME)) begin
              state     <= DONE;
              anim_busy <= 1'b0;
            end
          end
        end else begin
          tick_cnt <= tick_cnt + 4'd1;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_sprite_renderer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_sprite_renderer
//  Purpose  : Randomised scoreboard bench for sprite_renderer with a
//             behavioural raster/animation model and a synchronous ROM.
//  Revision : 1.0  initial release
// ============================================================================
module tb_sprite_renderer;

  localparam int W      = 64;
  localparam int H      = 64;
  localparam int FR     = 4;
  localparam int AW     = 14;
  localparam int NCYC   = 6000;
  localparam int TICKP  = 16;
  localparam int RST_AT = 3000;

  logic          vga_clk = 1'b0;
  logic          Reset   = 1'b1;
  logic [9:0]    DrawX = '0, DrawY = '0, pos_x = '0, pos_y = '0;
  logic          blank = 1'b0, frame_tick = 1'b0, flip_h = 1'b0;
  logic          play = 1'b0, loop_mode = 1'b0;
  logic [1:0]    scale = '0;
  logic [3:0]    anim_div = '0;
  logic [AW-1:0] rom_address;
  logic [3:0]    rom_q = '0;
  logic [3:0]    pix_idx;
  logic          pix_hit;
  logic [1:0]    anim_frame;
  logic          anim_busy;

  sprite_renderer #(
    .SPRITE_W(W), .SPRITE_H(H), .FRAMES(FR), .IDX_W(4), .TRANSP_IDX(0)
  ) dut (
    .vga_clk(vga_clk), .Reset(Reset), .DrawX(DrawX), .DrawY(DrawY),
    .blank(blank), .frame_tick(frame_tick), .pos_x(pos_x), .pos_y(pos_y),
    .scale(scale), .flip_h(flip_h), .play(play), .loop_mode(loop_mode),
    .anim_div(anim_div), .rom_address(rom_address), .rom_q(rom_q),
    .pix_idx(pix_idx), .pix_hit(pix_hit), .anim_frame(anim_frame),
    .anim_busy(anim_busy)
  );

  always #5 vga_clk = ~vga_clk;

  // Sprite ROM: one-cycle synchronous read
  logic [3:0] rom [0:FR*W*H-1];
  always @(posedge vga_clk) rom_q <= rom[rom_address];

  typedef struct { int due; int addr; int frame; int busy; } e1_t;
  typedef struct { int due; int idx; int hit; } e3_t;
  e1_t q1[$];
  e3_t q3[$];

  int cyc = 0;
  int n_vec = 0;
  int n_mis = 0;
  int tick_cd = 0;

  // Reference model state
  int m_sx, m_sy, m_sc, m_fl, m_lat;
  int m_active, m_n, m_div, m_loop;

  task automatic chk(input string nm, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_mis++;
      $display("FAIL %s cycle %0d: got %0d, expected %0d", nm, cyc, act, exp);
    end
  endtask

  task automatic model_reset();
    m_sx = 0; m_sy = 0; m_sc = 0; m_fl = 0; m_lat = 0;
    m_active = 0; m_n = 0; m_div = 1; m_loop = 0;
  endtask

  // Frame shown after m_n ticks since play: steps = m_n / div
  function automatic int model_frame();
    int s;
    if (m_active == 0) return 0;
    s = m_n / m_div;
    if (m_loop != 0) return s % FR;
    return (s < FR - 1) ? s : FR - 1;
  endfunction

  function automatic int model_busy();
    if (m_active == 0) return 0;
    if (m_loop != 0) return 1;
    return ((m_n / m_div) < FR - 1) ? 1 : 0;
  endfunction

  task automatic drive_cycle();
    int lx, ly, cx, cy, addr, idx, ext, hit, inb, ft, pl;
    e1_t e1;
    e3_t e3;
    if ($urandom_range(0, 24) == 0) begin
      pos_x  = ($urandom_range(0, 9) == 0) ? 10'($urandom_range(600, 1023))
                                           : 10'($urandom_range(0, 620));
      pos_y  = ($urandom_range(0, 9) == 0) ? 10'($urandom_range(440, 1023))
                                           : 10'($urandom_range(0, 470));
      scale  = 2'($urandom_range(0, 3));
      flip_h = 1'($urandom_range(0, 1));
    end
    ft = (tick_cd == 0) ? 1 : 0;
    tick_cd = (ft != 0) ? TICKP - 1 : tick_cd - 1;
    pl = (cyc == 20 || $urandom_range(0, 499) == 0) ? 1 : 0;
    if (pl != 0) begin
      anim_div  = 4'($urandom_range(0, 3));
      loop_mode = 1'($urandom_range(0, 1));
    end
    frame_tick = 1'(ft);
    play       = 1'(pl);
    ext = W << m_sc;
    if ($urandom_range(0, 3) != 0) begin
      DrawX = 10'(m_sx + int'($urandom_range(0, ext + 6)) - 3);
      DrawY = 10'(m_sy + int'($urandom_range(0, ext + 6)) - 3);
    end else begin
      DrawX = 10'($urandom_range(0, 799));
      DrawY = 10'($urandom_range(0, 524));
    end
    blank = (DrawX < 10'd640) && (DrawY < 10'd480) && ($urandom_range(0, 15) != 0);

    // Pixel expectation uses the shadow state in force before this edge
    lx  = int'(DrawX) - m_sx;
    ly  = int'(DrawY) - m_sy;
    inb = (lx >= 0 && ly >= 0 && lx < (W << m_sc) && ly < (H << m_sc)) ? 1 : 0;
    addr = 0;
    if (inb != 0) begin
      cx = lx >> m_sc;
      cy = ly >> m_sc;
      if (m_fl != 0) cx = W - 1 - cx;
      addr = m_lat * W * H + cy * W + cx;
    end
    idx = int'(rom[addr]);
    hit = (inb != 0 && blank && idx != 0) ? 1 : 0;

    // Animation and shadow update at this edge
    if (pl != 0) begin
      m_active = 1; m_n = 0; m_loop = int'(loop_mode);
      m_div = (anim_div == 4'd0) ? 1 : int'(anim_div);
      if (ft != 0) m_lat = 0;
    end else if (ft != 0) begin
      m_n++;
      m_lat = model_frame();
    end
    if (ft != 0) begin
      m_sx = int'(pos_x); m_sy = int'(pos_y); m_sc = int'(scale); m_fl = int'(flip_h);
    end

    e1.due = cyc + 1; e1.addr = addr; e1.frame = model_frame(); e1.busy = model_busy();
    e3.due = cyc + 3; e3.hit = hit; e3.idx = (hit != 0) ? idx : 0;
    q1.push_back(e1);
    q3.push_back(e3);
  endtask

  // Monitor: compare whatever the DUT presents against due expectations
  initial begin
    e1_t a;
    e3_t b;
    forever begin
      @(posedge vga_clk);
      cyc++;
      #1;
      while (q1.size() > 0 && q1[0].due == cyc) begin
        a = q1.pop_front();
        chk("rom_address", int'(rom_address), a.addr);
        chk("anim_frame", int'(anim_frame), a.frame);
        chk("anim_busy", int'(anim_busy), a.busy);
      end
      while (q3.size() > 0 && q3[0].due == cyc) begin
        b = q3.pop_front();
        chk("pix_hit", int'(pix_hit), b.hit);
        chk("pix_idx", int'(pix_idx), b.idx);
      end
    end
  end

  // Stimulus
  initial begin
    for (int i = 0; i < FR * W * H; i++)
      rom[i] = ($urandom_range(0, 3) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
    model_reset();
    repeat (2) @(negedge vga_clk);
    chk("reset rom_address", int'(rom_address), 0);
    chk("reset pix_hit", int'(pix_hit), 0);
    chk("reset pix_idx", int'(pix_idx), 0);
    chk("reset anim_frame", int'(anim_frame), 0);
    chk("reset anim_busy", int'(anim_busy), 0);
    for (int c = 0; c < NCYC; c++) begin
      @(negedge vga_clk);
      if (c >= RST_AT && c < RST_AT + 3) begin
        if (c == RST_AT) begin
          Reset = 1'b1;
          frame_tick = 1'b0;
          play = 1'b0;
          #1;
          chk("midline pix_hit", int'(pix_hit), 0);
          chk("midline pix_idx", int'(pix_idx), 0);
          chk("midline anim_frame", int'(anim_frame), 0);
          chk("midline anim_busy", int'(anim_busy), 0);
          chk("midline rom_address", int'(rom_address), 0);
          q1.delete();
          q3.delete();
          model_reset();
          tick_cd = 0;
        end
      end else begin
        Reset = 1'b0;
        drive_cycle();
      end
    end
    @(negedge vga_clk);
    frame_tick = 1'b0;
    play = 1'b0;
    repeat (5) @(negedge vga_clk);
    chk("queue drained", q1.size() + q3.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
`default_nettype wire
